// File: rtl/snn_pkg.sv
// Shared constants and helpers for the spiking delay core.
//   N_IN/N_NEU  : input channels / neurons (fixed at 4)
//   W_BITS      : signed synapse weight width (-4..3)
//   D_BITS      : synapse delay width (0..3 cycles)
//   V_BITS      : unsigned saturating membrane width
//   CFG_LEN     : config shift register length (16 synapses x 5 bits)
//   cfg_w/cfg_d : low bit index of a synapse's weight / delay field
//   clamp_u     : saturate a signed intermediate membrane value to 0..255
package snn_pkg;
    localparam int N_IN     = 4;
    localparam int N_NEU    = 4;
    localparam int W_BITS   = 3;
    localparam int D_BITS   = 2;
    localparam int V_BITS   = 8;
    localparam int CFG_LEN  = 80;
    localparam int SYN_BITS = W_BITS + D_BITS;
    localparam int N_SYN    = N_IN * N_NEU;
    localparam int DEPTH    = 4;    // delay taps per input (0..3)
    localparam int S_BITS   = 6;    // weighted sum range -16..12
    localparam int U_BITS   = 11;   // headroom for v - L + S

    // Synapse s = 4*i + j; its field is [5s+4:5s] = {weight, delay}.
    function automatic int cfg_w(input int s);
        return SYN_BITS * s + D_BITS;
    endfunction

    function automatic int cfg_d(input int s);
        return SYN_BITS * s;
    endfunction

    function automatic logic [V_BITS-1:0] clamp_u(input logic signed [U_BITS-1:0] u);
        if (u < 0)
            return '0;
        else if (u > 11'sd255)
            return '1;
        else
            return u[V_BITS-1:0];
    endfunction
endpackage

// File: rtl/snn_lif_neuron.sv
// Integrate-and-fire neuron with constant leak, threshold and reset-to-zero.
//   clk, srst : clock and synchronous active-high reset
//   advance   : perform one integrate/fire step this edge
//   clear     : zero membrane and spike (config load in progress)
//   s_sum     : signed weighted input sum for this step
//   thr, leak : threshold (0 disables firing) and per-step leak
//   v, spike  : registered membrane and single-cycle spike pulse
module snn_lif_neuron
    import snn_pkg::*;
(
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     advance,
    input  logic                     clear,
    input  logic signed [S_BITS-1:0] s_sum,
    input  logic [3:0]               thr,
    input  logic [3:0]               leak,
    output logic [V_BITS-1:0]        v,
    output logic                     spike
);
    logic [V_BITS-1:0]        v_reg;
    logic                     spike_reg;
    logic signed [U_BITS-1:0] u_raw;
    logic [V_BITS-1:0]        u_clamped;
    logic                     fire;

    always_comb begin
        u_raw     = $signed({3'b000, v_reg}) - $signed({7'b0000000, leak})
                    + $signed({{(U_BITS-S_BITS){s_sum[S_BITS-1]}}, s_sum});
        u_clamped = clamp_u(u_raw);
        fire      = (thr != 4'd0) && (u_clamped >= {4'b0000, thr});
    end

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            v_reg     <= '0;
            spike_reg <= 1'b0;
        end else if (advance) begin
            spike_reg <= fire;
            v_reg     <= fire ? '0 : u_clamped;
        end
    end

    assign v     = v_reg;
    assign spike = spike_reg;
endmodule

// File: rtl/snn_delay_core.sv
// 4-input, 4-neuron spiking layer with per-synapse weight and axonal delay.
//   clk     : clock
//   rst_n   : synchronous reset, active HIGH despite the wrapper pin name
//   ena     : 1 = advance state, 0 = hold everything (reset still applies)
//   ui_in   : [3:0] spikes, [4] cfg_en, [5] cfg_bit, [7:6] unused
//   uio_in  : [3:0] threshold, [7:4] leak
//   uo_out  : [3:0] neuron spikes, [7:4] min(v0,15)
//   uio_out : tied 0;  uio_oe : tied 0 (all bidir pins are inputs)
module snn_delay_core
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic srst;
    logic cfg_en;
    logic cfg_bit;
    logic advance;
    logic clear;
    logic [3:0] thr;
    logic [3:0] leak;

    assign srst    = rst_n;
    assign cfg_en  = ui_in[4];
    assign cfg_bit = ui_in[5];
    assign advance = ena & ~cfg_en;
    assign clear   = ena & cfg_en;
    assign thr     = uio_in[3:0];
    assign leak    = uio_in[7:4];

    logic [CFG_LEN-1:0]      cfg_reg;
    logic [DEPTH-1:0]        h_reg [N_IN];   // bit k = input seen k+1 edges ago
    logic signed [W_BITS-1:0] syn_w [N_SYN];
    logic [D_BITS-1:0]       syn_d [N_SYN];
    logic [N_SYN-1:0]        syn_hit;
    logic [V_BITS-1:0]       v_all [N_NEU];
    logic [N_NEU-1:0]        spike_vec;

    // First bit shifted in lands at bit 79 after a full load.
    always_ff @(posedge clk) begin
        if (srst)
            cfg_reg <= '0;
        else if (clear)
            cfg_reg <= {cfg_reg[CFG_LEN-2:0], cfg_bit};
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_delay
            always_ff @(posedge clk) begin
                if (srst || clear)
                    h_reg[gi] <= '0;
                else if (advance)
                    h_reg[gi] <= {h_reg[gi][DEPTH-2:0], ui_in[gi]};
            end
        end

        for (gi = 0; gi < N_SYN; gi++) begin : g_syn
            assign syn_w[gi]   = cfg_reg[cfg_w(gi) +: W_BITS];
            assign syn_d[gi]   = cfg_reg[cfg_d(gi) +: D_BITS];
            assign syn_hit[gi] = h_reg[gi / N_NEU][syn_d[gi]];
        end

        for (gi = 0; gi < N_NEU; gi++) begin : g_neu
            logic signed [S_BITS-1:0] s_sum;

            always_comb begin
                s_sum = '0;
                for (int i = 0; i < N_IN; i++) begin
                    if (syn_hit[N_NEU*i + gi])
                        s_sum = s_sum + {{(S_BITS-W_BITS){syn_w[N_NEU*i + gi][W_BITS-1]}},
                                         syn_w[N_NEU*i + gi]};
                end
            end

            snn_lif_neuron u_neuron (
                .clk     (clk),
                .srst    (srst),
                .advance (advance),
                .clear   (clear),
                .s_sum   (s_sum),
                .thr     (thr),
                .leak    (leak),
                .v       (v_all[gi]),
                .spike   (spike_vec[gi])
            );
        end
    endgenerate

    logic [3:0] v0_sat;
    assign v0_sat  = (v_all[0] > 8'd15) ? 4'hF : v_all[0][3:0];
    assign uo_out  = {v0_sat, spike_vec};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_pins;
    assign unused_pins = &{1'b0, ui_in[7:6]};
endmodule

// File: tb/tb_snn_delay_core.sv
// Self-checking bench: directed scenarios plus randomized run/config traffic,
// all compared each cycle against a behavioural model of the network.
module tb_snn_delay_core;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit [79:0] m_cfg;
    bit [3:0]  m_h [4];   // m_h[i][k]: input i as seen k+1 edges ago
    int        m_v [4];
    bit [3:0]  m_spk;

    snn_delay_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int weight_of(input int s);
        int x;
        x = int'(m_cfg[5*s+2 +: 3]);
        if (x > 3) x -= 8;
        return x;
    endfunction

    function automatic int delay_of(input int s);
        return int'(m_cfg[5*s +: 2]);
    endfunction

    function automatic logic [7:0] exp_uo();
        logic [3:0] hi;
        hi = (m_v[0] > 15) ? 4'hF : 4'(m_v[0]);
        return {hi, m_spk};
    endfunction

    // One edge of the model, using the values currently driven on the pins.
    task automatic model_edge();
        int thr, leak, s, u;
        int nv [4];
        bit [3:0] ns;
        thr  = int'(uio_in[3:0]);
        leak = int'(uio_in[7:4]);
        if (rst_n) begin
            m_cfg = '0; m_spk = '0;
            for (int i = 0; i < 4; i++) begin m_h[i] = '0; m_v[i] = 0; end
        end else if (ena) begin
            if (ui_in[4]) begin
                m_cfg = {m_cfg[78:0], ui_in[5]};
                m_spk = '0;
                for (int i = 0; i < 4; i++) begin m_h[i] = '0; m_v[i] = 0; end
            end else begin
                for (int j = 0; j < 4; j++) begin
                    s = 0;
                    for (int i = 0; i < 4; i++)
                        if (m_h[i][delay_of(4*i+j)]) s += weight_of(4*i+j);
                    u = m_v[j] - leak + s;
                    if (u < 0) u = 0;
                    if (u > 255) u = 255;
                    if (thr != 0 && u >= thr) begin ns[j] = 1'b1; nv[j] = 0; end
                    else begin ns[j] = 1'b0; nv[j] = u; end
                end
                for (int j = 0; j < 4; j++) m_v[j] = nv[j];
                m_spk = ns;
                for (int i = 0; i < 4; i++) m_h[i] = {m_h[i][2:0], ui_in[i]};
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
        rst_n = r; ena = e; ui_in = ui; uio_in = uio;
        @(posedge clk);
        model_edge();
        #1;
        check("uo_out_model", uo_out, exp_uo());
        check("uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);
    endtask

    task automatic load_cfg(input bit [79:0] word, input logic [7:0] uio);
        for (int b = 79; b >= 0; b--)
            step(1'b0, 1'b1, {2'b00, word[b], 1'b1, 4'b0000}, uio);
        $display("load cfg=%020h uio=%02h", word, uio);
    endtask

    function automatic bit [79:0] syn0(input bit [2:0] w, input bit [1:0] d);
        bit [79:0] c;
        c = '0;
        c[4:0] = {w, d};
        return c;
    endfunction

    initial begin
        bit [79:0] rw;
        logic [7:0] cur_uio;
        logic [7:0] ui;
        int r;

        rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

        // Reset and zero-config quiescence
        step(1'b1, 1'b1, 8'h00, 8'h00);
        step(1'b1, 1'b1, 8'h00, 8'h00);
        check("reset_uo", uo_out, 8'h00);
        $display("reset uo=%02h", uo_out);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'h0F, 8'h00);
        check("zero_cfg_uo", uo_out, 8'h00);

        // w00=3, d00=0: spike one cycle after sampling
        load_cfg(syn0(3'b011, 2'b00), 8'h03);
        step(1'b0, 1'b1, 8'h01, 8'h03);
        check("d0_e0", uo_out, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h03);
        check("d0_e1", uo_out, 8'h01);
        step(1'b0, 1'b1, 8'h00, 8'h03);
        check("d0_e2", uo_out, 8'h00);
        $display("delay0 test uo=%02h", uo_out);

        // d00=3: spike appears only after E4
        load_cfg(syn0(3'b011, 2'b11), 8'h03);
        step(1'b0, 1'b1, 8'h01, 8'h03);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 8'h00, 8'h03);
            check("d3_quiet", uo_out, 8'h00);
        end
        step(1'b0, 1'b1, 8'h00, 8'h03);
        check("d3_e4", uo_out, 8'h01);
        $display("delay3 test uo=%02h", uo_out);

        // w00=1, T=3: integrate 1, 2 then fire
        load_cfg(syn0(3'b001, 2'b00), 8'h03);
        step(1'b0, 1'b1, 8'h01, 8'h03);
        step(1'b0, 1'b1, 8'h01, 8'h03);
        check("int_v1", uo_out, 8'h10);
        step(1'b0, 1'b1, 8'h01, 8'h03);
        check("int_v2", uo_out, 8'h20);
        step(1'b0, 1'b1, 8'h00, 8'h03);
        check("int_fire", uo_out, 8'h01);
        $display("integrate test uo=%02h", uo_out);

        // Leak cancels input; negative weight clamps at 0
        load_cfg(syn0(3'b001, 2'b00), 8'h13);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'h01, 8'h13);
        check("leak_v0", uo_out, 8'h00);
        load_cfg(syn0(3'b100, 2'b00), 8'h03);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'h01, 8'h03);
        check("neg_clamp", uo_out, 8'h00);
        $display("leak/clamp test uo=%02h", uo_out);

        // Freeze with ena=0, then a single cfg_en edge clears state
        load_cfg(syn0(3'b001, 2'b00), 8'h03);
        step(1'b0, 1'b1, 8'h01, 8'h03);
        step(1'b0, 1'b1, 8'h01, 8'h03);
        step(1'b0, 1'b1, 8'h00, 8'h03);
        check("pre_freeze", uo_out, 8'h20);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 8'($urandom), 8'h03);
            check("frozen", uo_out, 8'h20);
        end
        step(1'b0, 1'b1, 8'h10, 8'h03);
        check("cfg_edge_clear", uo_out, 8'h00);
        $display("freeze/cfg-clear test uo=%02h", uo_out);

        // Randomized traffic against the model
        cur_uio = 8'h02;
        for (int n = 0; n < 2500; n++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                step(1'b1, 1'($urandom), 8'($urandom), cur_uio);
                $display("random reset uo=%02h", uo_out);
            end else if (r < 4) begin
                rw = {16'($urandom), $urandom, $urandom};
                cur_uio = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 6))};
                load_cfg(rw, cur_uio);
            end else begin
                ui = 8'($urandom);
                ui[4] = ($urandom_range(0, 39) == 0);
                step(1'b0, ($urandom_range(0, 9) != 0), ui, cur_uio);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/snn_delay_core.md
Name: snn_delay_core

Overview:
- Tiny Tapeout top-level for a 4-input, 4-neuron single-layer spiking network.
- Each of the 16 synapses has a programmable signed weight and a 0–3 cycle axonal delay.
- Neurons are integrate-and-fire with a constant leak, a threshold and reset-to-zero.
- Weights and delays are loaded through a serial shift port; threshold and leak are live pin inputs.

Parameters:
- N_IN, 4: input spike channels (fixed).
- N_NEU, 4: output neurons (fixed).
- W_BITS, 3: synapse weight width, two's complement, range -4..3.
- D_BITS, 2: synapse delay width, range 0..3 cycles.
- V_BITS, 8: membrane width, unsigned, saturating 0..255.
- CFG_LEN, 80: config shift-register length, 16 synapses × 5 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, per the interface decision: one clock; reset is synchronous and active-high. The pin keeps the wrapper's name; rst_n=1 at a rising edge resets.
- ena  in  1  1 = advance state; 0 = hold all registers (reset still applies).
- ui_in  in  8  [3:0] input spikes; [4] cfg_en; [5] cfg_bit; [7:6] ignored.
- uio_in  in  8  [3:0] threshold T (unsigned); [7:4] leak L (unsigned).
- uo_out  out  8  [3:0] registered spikes of neurons 3..0; [7:4] min(v0,15).
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs).

Behaviour:
- Reset: config register, histories h, membranes v and spike register are all 0. Consequently uo_out=0.
- Config word layout:
  - Synapse s = 4*i + j (i = input, j = neuron) occupies bits [5s+4:5s].
  - [5s+4:5s+2] is weight w_ij; [5s+1:5s] is delay d_ij.
- Config load: edge with ena=1 and cfg_en=1 does cfg <= {cfg[78:0], cfg_bit}.
  - The first bit loaded ends in bit 79 after 80 shifts.
  - During the same edge, h, v and spikes are cleared to 0.
- Run: every edge with ena=1 and cfg_en=0 performs the following, all computed from pre-edge values:
  - Delay line per input i: h_i[0] <= ui_in[i]; h_i[k] <= h_i[k-1] for k = 1..3.
  - Per neuron j: S_j = sum over i of (h_i[d_ij] ? w_ij : 0). S_j is signed, range -16..12.
  - u_j = v_j - L + S_j, computed signed 11-bit, then clamped to 0..255.
  - If T != 0 and u_j >= T: spike_j <= 1 and v_j <= 0. Otherwise spike_j <= 0 and v_j <= u_j.
  - T = 0 disables firing entirely; the neuron still integrates.
- Latency:
  - A spike sampled at edge E0 lands in h_i[d] after edge E0+d.
  - It contributes to v at edge E0+d+1.
  - The output spike is visible on uo_out after that same edge, i.e. d+1 cycles after sampling.
- Output spikes are single-cycle pulses per firing. A neuron may fire on consecutive cycles.
- uo_out[7:4] reflects the registered v0, saturated to 15.
- Reset takes priority over ena and cfg_en.
- Reset mid-load discards any partial config.
- Config persists across run periods until the next load or reset.

Decomposition:
- Package snn_pkg holds:
  - N_IN, N_NEU, W_BITS, D_BITS, V_BITS, CFG_LEN;
  - a function cfg_w(s) returning the weight bit index of synapse s;
  - a function cfg_d(s) returning the delay bit index of synapse s;
  - the clamp helper.
- One sub-module snn_lif_neuron, instantiated 4×:
  - inputs: weighted sum S, T, L, clear, advance;
  - outputs: v, spike.
- Delay lines, synapse mux/sum and config shifter stay in the top.

Test Plan:
- Reset (rst_n=1 for 2 edges, ena=1) -> uo_out=0x00, uio_out=0x00, uio_oe=0x00. Holding ui_in=0x0F afterwards with all-zero config keeps uo_out=0x00.
- Load w00=3, d00=0 (all others 0); T=3, L=0; ui_in[0]=1 for one edge E0 -> uo_out[0]=1 exactly after E1 for one cycle; uo_out[7:4]=0.
- Same with d00=3 -> uo_out[0] rises only after E4. Edges E1..E3 give uo_out=0x00.
- w00=1, d00=0, T=3, L=0, three consecutive input spikes -> uo_out[7:4] reads 1, 2, then the spike fires with [7:4]=0.
- w00=1, L=1, continuous input -> v0 stays 0 and no spike ever. Then w00=-4 with input -> v0 clamps at 0, with no wrap to 252.
- After v0=2, assert cfg_en for one edge -> v0=0, spikes 0, and cfg shifted by one bit. ena=0 for 5 cycles -> all outputs frozen.
